exec_wb_unit: RTL and testbench

- Single-issue execute/writeback stage directly upstream of the 16x32 register file.
- Accepts one decoded instruction (op, rd, rs1, rs2) over a valid/ready handshake and drives the regfile read ports (rpa/rpb, douta/doutb).
- Computes the result (single-cycle ALU ops, or an iterative 32-cycle multiply) and drives the regfile write port (wp/we/din) for exactly one cycle.
- Only one instruction is in flight, so there are no data hazards.

---
 rtl/exec_wb_unit.sv | 202 ++++++++++++++++++++
 tb/tb_exec_wb_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_wb_unit.sv
// Execute/writeback stage feeding a 16x32 register file.
// Takes one decoded instruction at a time over valid/ready, reads both
// sources, computes an ALU result (or a WIDTH-cycle shift-add multiply),
// and drives the regfile write port for one cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   instruction handshake (in_ready is combinational)
//   in_op/rd/rs1/rs2    decoded instruction fields
//   rpa, rpb            regfile read indices (registered)
//   douta, doutb        regfile read data (combinational from rpa/rpb)
//   wp, we, din         regfile write port (registered)
//   busy                high in READ or EXEC
//   done                one-cycle pulse during WB
module exec_wb_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  output logic [AW-1:0]    rpa,
  output logic [AW-1:0]    rpb,
  input  logic [WIDTH-1:0] douta,
  input  logic [WIDTH-1:0] doutb,
  output logic [AW-1:0]    wp,
  output logic             we,
  output logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done
);

  localparam int unsigned OPW = 4;
  localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_AND  = 4'd2;
  localparam logic [OPW-1:0] OP_OR   = 4'd3;
  localparam logic [OPW-1:0] OP_XOR  = 4'd4;
  localparam logic [OPW-1:0] OP_SLL  = 4'd5;
  localparam logic [OPW-1:0] OP_SRL  = 4'd6;
  localparam logic [OPW-1:0] OP_SRA  = 4'd7;
  localparam logic [OPW-1:0] OP_SLT  = 4'd8;
  localparam logic [OPW-1:0] OP_SLTU = 4'd9;
  localparam logic [OPW-1:0] OP_MUL  = 4'd10;
  localparam logic [OPW-1:0] OP_MOVB = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    rpa_d, rpb_d, wp_d;
  logic [WIDTH-1:0] din_d;
  logic             we_d, busy_d, done_d;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_sum;
  logic [CW-1:0]    shamt;
  logic             accept;
  logic             wr_ok;

  assign in_ready = !rst && (state_q == S_IDLE || state_q == S_WB);
  assign accept   = in_valid && in_ready;
  // r0 reads as zero and r15 is hardwired to one, so neither is ever written
  assign wr_ok    = (op_q <= OP_MOVB) && (rd_q != '0) && (rd_q != '1);

  // Single-cycle ALU on the captured operands
  always_comb begin
    alu_res = '0;
    shamt   = b_q[CW-1:0];
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL:  alu_res = a_q << shamt;
      OP_SRL:  alu_res = a_q >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(a_q) >>> shamt);
      OP_SLT:  alu_res = WIDTH'($signed(a_q) < $signed(b_q));
      OP_SLTU: alu_res = WIDTH'(a_q < b_q);
      OP_MOVB: alu_res = b_q;
      default: alu_res = '0;
    endcase
  end

  // Shift-add step: a_q carries the multiplicand shifted left, b_q the
  // multiplier shifted right, so bit 0 of b_q is always the current bit
  assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rpa_d   = rpa;
    rpb_d   = rpb;
    wp_d    = wp;
    din_d   = din;
    we_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_READ: begin
        a_d     = douta;
        b_d     = doutb;
        acc_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          a_d    = a_q << 1;
          b_d    = b_q >> 1;
          acc_d  = mul_sum;
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            din_d   = mul_sum;
            wp_d    = rd_q;
            we_d    = wr_ok;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_WB;
          end
        end else begin
          din_d   = alu_res;
          wp_d    = rd_q;
          we_d    = wr_ok;
          done_d  = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Accept only happens in IDLE or WB; in WB this gives back-to-back issue
    if (accept) begin
      op_d    = in_op;
      rd_d    = in_rd;
      rpa_d   = in_rs1;
      rpb_d   = in_rs2;
      busy_d  = 1'b1;
      state_d = S_READ;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rpa     <= '0;
      rpb     <= '0;
      wp      <= '0;
      din     <= '0;
      we      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rpa     <= rpa_d;
      rpb     <= rpb_d;
      wp      <= wp_d;
      din     <= din_d;
      we      <= we_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_exec_wb_unit.sv
// Self-checking bench for exec_wb_unit: an architectural register-file
// model computes each instruction's expected write in program order and
// a negedge monitor compares every writeback, its latency and busy span.
module tb_exec_wb_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned AW    = 4;
  localparam int          CLK_P = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [AW-1:0]    in_rd, in_rs1, in_rs2;
  logic [AW-1:0]    rpa, rpb, wp;
  logic [WIDTH-1:0] douta, doutb, din;
  logic             we, busy, done;

  exec_wb_unit #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .rpa(rpa), .rpb(rpb), .douta(douta), .doutb(doutb),
    .wp(wp), .we(we), .din(din), .busy(busy), .done(done)
  );

  always #(CLK_P/2) clk = ~clk;

  // Environment register file the DUT reads and writes
  logic [WIDTH-1:0] rf [16];
  logic             pre_en;
  logic [3:0]       pre_idx;
  logic [WIDTH-1:0] pre_val;

  assign douta = (rpa == 4'd0) ? 32'd0 : (rpa == 4'hF) ? 32'd1 : rf[rpa];
  assign doutb = (rpb == 4'd0) ? 32'd0 : (rpb == 4'hF) ? 32'd1 : rf[rpb];

  always @(posedge clk) begin
    if (pre_en) rf[pre_idx] <= pre_val;
    else if (we && wp != 4'd0 && wp != 4'hF) rf[wp] <= din;
  end

  // Reference model state
  typedef struct {
    logic [3:0]  wp;
    logic [31:0] din;
    logic        we;
    logic        chk_din;
    int          cyc;
    int          lat;
  } exp_t;

  logic [31:0] mrf [16];
  exp_t        exp_q [$];
  int          cyc = 0;
  int          busy_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [3:0] r);
    if (r == 4'd0) return 32'd0;
    if (r == 4'hF) return 32'd1;
    return mrf[r];
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    int          sh;
    sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return 32'($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      4'd11: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Negedge monitor: retire the writeback, then register a new accept
  task automatic monitor();
    exp_t        e;
    logic [31:0] a, b;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        busy_cnt = 0;
      end else begin
        if (busy) begin
          busy_cnt++;
          check("ready_while_busy", in_ready, 1'b0);
        end
        if (done) begin
          if (exp_q.size() == 0) check("spurious_done", done, 1'b0);
          else begin
            e = exp_q.pop_front();
            check("wp", wp, e.wp);
            check("we", we, e.we);
            if (e.chk_din) check("din", din, e.din);
            check("latency", cyc - e.cyc, e.lat);
            check("busy_cycles", busy_cnt, e.lat - 1);
            if (e.we) mrf[e.wp] = e.din;
            busy_cnt = 0;
          end
        end else check("we_without_done", we, 1'b0);
        if (in_valid && in_ready) begin
          a = mrd(in_rs1);
          b = mrd(in_rs2);
          e.wp      = in_rd;
          e.din     = ref_alu(in_op, a, b);
          e.we      = (in_op <= 4'd11) && in_rd != 4'd0 && in_rd != 4'hF;
          e.chk_din = (in_op <= 4'd11);
          e.cyc     = cyc;
          e.lat     = (in_op == 4'd10) ? WIDTH + 2 : 3;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic preset(input logic [3:0] r, input logic [31:0] v);
    pre_en = 1'b1; pre_idx = r; pre_val = v;
    mrf[r] = v;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, output int t);
    bit ok = 1'b0;
    t = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; t = int'($time); end
    end
    check("accept_timeout", ok, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    check("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    #(CLK_P * 80000);
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3;
    logic [31:0] saved;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    fork monitor(); join_none

    for (int r = 0; r < 16; r++) preset(4'(r), $urandom);
    @(negedge clk);
    check("rst_rpa", rpa, 4'd0);
    check("rst_rpb", rpb, 4'd0);
    check("rst_wp", wp, 4'd0);
    check("rst_din", din, 32'd0);
    check("rst_we", we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1'b1);
    @(posedge clk); #1;

    // ADD then dependent back-to-back ADD using r15
    preset(4'd1, 32'd5);
    preset(4'd2, 32'd7);
    send(4'd0, 4'd3, 4'd1, 4'd2, t0);
    send(4'd0, 4'd5, 4'd3, 4'hF, t1);
    drain();
    check("add_r3", rf[3], 32'd12);
    check("dep_add_r5", rf[5], 32'd13);
    check("b2b_gap", t1 - t0, 3 * CLK_P);

    // Multiply with wrap-around
    preset(4'd1, 32'hFFFF_FFFF);
    preset(4'd2, 32'd3);
    send(4'd10, 4'd4, 4'd1, 4'd2, t0);
    drain();
    check("mul_r4", rf[4], 32'hFFFF_FFFD);

    // Shifts and compares
    preset(4'd1, 32'h8000_0000);
    preset(4'd2, 32'd4);
    preset(4'd8, 32'd33);
    preset(4'd12, 32'h1234_5678);
    preset(4'd10, 32'hFFFF_FFFF);
    preset(4'd11, 32'd1);
    send(4'd7, 4'd6, 4'd1, 4'd2, t0);
    send(4'd6, 4'd7, 4'd1, 4'd2, t0);
    send(4'd5, 4'd9, 4'd12, 4'd8, t0);
    send(4'd8, 4'd13, 4'd10, 4'd11, t0);
    send(4'd9, 4'd14, 4'd10, 4'd11, t0);
    drain();
    check("sra", rf[6], 32'hF800_0000);
    check("srl", rf[7], 32'h0800_0000);
    check("sll_33", rf[9], 32'h2468_ACF0);
    check("slt", rf[13], 32'd1);
    check("sltu", rf[14], 32'd0);

    // Non-writing cases: rd=0, rd=15, NOP
    send(4'd0, 4'd0, 4'd1, 4'd2, t0);
    send(4'd0, 4'hF, 4'd1, 4'd2, t0);
    send(4'd13, 4'd6, 4'd1, 4'd2, t0);
    drain();
    check("nop_kept_r6", rf[6], 32'hF800_0000);

    // Reset in the middle of a multiply
    saved = rf[5];
    send(4'd10, 4'd5, 4'd10, 4'd2, t0);
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("ready_in_rst", in_ready, 1'b0);
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_we", we, 1'b0);
    check("abort_rpa", rpa, 4'd0);
    check("abort_rpb", rpb, 4'd0);
    check("abort_wp", wp, 4'd0);
    check("abort_din", din, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", in_ready, 1'b1);
    repeat (40) @(negedge clk);
    check("abort_no_write", rf[5], saved);
    @(posedge clk); #1;

    // Continuous in_valid: accepts every third cycle
    send(4'd0, 4'd1, 4'd2, 4'd3, t0);
    send(4'd4, 4'd2, 4'd1, 4'd5, t1);
    send(4'd1, 4'd3, 4'd2, 4'd1, t2);
    send(4'd11, 4'd4, 4'd0, 4'd3, t3);
    drain();
    check("stream_gap1", t1 - t0, 3 * CLK_P);
    check("stream_gap2", t2 - t1, 3 * CLK_P);
    check("stream_gap3", t3 - t2, 3 * CLK_P);

    // Random instruction mix with random gaps
    for (int n = 0; n < 200; n++) begin
      if (n % 25 == 0) begin
        drain();
        preset(4'($urandom_range(1, 14)), $urandom);
      end
      send(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom), t0);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    drain();
    repeat (2) @(posedge clk);
    #1;
    for (int r = 1; r < 15; r++) check($sformatf("rf_final_r%0d", r), rf[r], mrf[r]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
